// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump block: dump FSM encodings and a clog2 helper.
package regfile_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_DUMP = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_DUMP = ST_DUMP
    } dump_state_e;

    // Ceiling log2 for toolchains that lack $clog2 in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump sequencer: walks idx over every entry once per request, handshaking on valid/ready.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          dump_start,
    input  logic          dump_ready,
    output logic          dump_valid,
    output logic          dump_busy,
    output logic          dump_done,
    output logic [AW-1:0] dump_idx
);

    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

    dump_state_e   r_state, w_state_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic          r_done, w_done_nxt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        dump_valid  = 1'b0;
        dump_busy   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dump_start) begin
                    w_state_nxt = S_DUMP;
                    w_idx_nxt   = '0;
                end
            end
            S_DUMP: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign dump_done = r_done;
    assign dump_idx  = r_idx;

endmodule

// File: rtl/regfile_dump.sv
// Parametrised register file with two async read ports, optional write bypass,
// a written-since-clear bitmap and a valid/ready dump stream of all entries.
module regfile_dump
    import regfile_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 8,
    parameter  int unsigned BYPASS = 0,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [AW-1:0]     wsel,
    input  logic [DATA_W-1:0] d,
    input  logic [AW-1:0]     rsel0,
    output logic [DATA_W-1:0] q0,
    input  logic [AW-1:0]     rsel1,
    output logic [DATA_W-1:0] q1,
    output logic [DEPTH-1:0]  written,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [AW-1:0]     dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_written;
    logic [AW-1:0]     w_idx;
    logic              w_wr_ok;

    assign w_wr_ok = en && ({1'b0, wsel} < DEPTH_W);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_written <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wsel]     <= d;
            r_written[wsel] <= 1'b1;
        end
    end

    // Shared by both read ports and the dump port so all three see identical bypass rules.
    function automatic logic [DATA_W-1:0] f_read(input logic [AW-1:0] a);
        if ((BYPASS != 0) && w_wr_ok && (a == wsel)) begin
            return d;
        end else if ({1'b0, a} < DEPTH_W) begin
            return r_mem[a];
        end
        return '0;
    endfunction

    always_comb begin
        q0        = f_read(rsel0);
        q1        = f_read(rsel1);
        dump_data = f_read(w_idx);
    end

    assign written   = r_written;
    assign dump_addr = w_idx;

    regfile_dump_fsm #(
        .DEPTH (DEPTH)
    ) u_fsm (
        .clk        (clk),
        .clr        (clr),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .dump_idx   (w_idx)
    );

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: three configurations driven in parallel against a behavioural model.
module tb_regfile_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr = 1'b1, en = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
    logic [2:0]  wsel = '0, rsel0 = '0, rsel1 = '0;
    logic [15:0] d16 = '0;
    logic [7:0]  d8;
    assign d8 = d16[7:0];

    logic [7:0]  q0_a, q1_a, dd_a, wr_a, q0_b, q1_b, dd_b, wr_b;
    logic [2:0]  da_a, da_b, da_c;
    logic        dv_a, db_a, dn_a, dv_b, db_b, dn_b, dv_c, db_c, dn_c;
    logic [15:0] q0_c, q1_c, dd_c;
    logic [4:0]  wr_c;

    regfile_dump #(.DATA_W(8), .DEPTH(8), .BYPASS(0)) u_a (
        .clk(clk), .clr(clr), .en(en), .wsel(wsel), .d(d8), .rsel0(rsel0), .q0(q0_a),
        .rsel1(rsel1), .q1(q1_a), .written(wr_a), .dump_start(dump_start), .dump_valid(dv_a),
        .dump_ready(dump_ready), .dump_addr(da_a), .dump_data(dd_a), .dump_busy(db_a),
        .dump_done(dn_a));

    regfile_dump #(.DATA_W(8), .DEPTH(8), .BYPASS(1)) u_b (
        .clk(clk), .clr(clr), .en(en), .wsel(wsel), .d(d8), .rsel0(rsel0), .q0(q0_b),
        .rsel1(rsel1), .q1(q1_b), .written(wr_b), .dump_start(dump_start), .dump_valid(dv_b),
        .dump_ready(dump_ready), .dump_addr(da_b), .dump_data(dd_b), .dump_busy(db_b),
        .dump_done(dn_b));

    regfile_dump #(.DATA_W(16), .DEPTH(5), .BYPASS(0)) u_c (
        .clk(clk), .clr(clr), .en(en), .wsel(wsel), .d(d16), .rsel0(rsel0), .q0(q0_c),
        .rsel1(rsel1), .q1(q1_c), .written(wr_c), .dump_start(dump_start), .dump_valid(dv_c),
        .dump_ready(dump_ready), .dump_addr(da_c), .dump_data(dd_c), .dump_busy(db_c),
        .dump_done(dn_c));

    logic [15:0] a_q0 [3], a_q1 [3], a_dd [3], a_da [3], a_wr [3];
    logic        a_dv [3], a_db [3], a_dn [3];
    assign a_q0[0] = {8'h0, q0_a}; assign a_q0[1] = {8'h0, q0_b}; assign a_q0[2] = q0_c;
    assign a_q1[0] = {8'h0, q1_a}; assign a_q1[1] = {8'h0, q1_b}; assign a_q1[2] = q1_c;
    assign a_dd[0] = {8'h0, dd_a}; assign a_dd[1] = {8'h0, dd_b}; assign a_dd[2] = dd_c;
    assign a_da[0] = {13'h0, da_a}; assign a_da[1] = {13'h0, da_b}; assign a_da[2] = {13'h0, da_c};
    assign a_wr[0] = {8'h0, wr_a}; assign a_wr[1] = {8'h0, wr_b}; assign a_wr[2] = {11'h0, wr_c};
    assign a_dv[0] = dv_a; assign a_dv[1] = dv_b; assign a_dv[2] = dv_c;
    assign a_db[0] = db_a; assign a_db[1] = db_b; assign a_db[2] = db_c;
    assign a_dn[0] = dn_a; assign a_dn[1] = dn_b; assign a_dn[2] = dn_c;

    int n_chk = 0, n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: instance 0 = 8x8, 1 = 8x8 with bypass, 2 = 16-bit x 5 entries.
    logic [15:0] m_mem [3][8];
    logic [7:0]  m_wr [3];
    bit          m_dump [3], m_done [3];
    int          m_idx [3];

    function automatic int dep(input int k);
        return (k == 2) ? 5 : 8;
    endfunction

    function automatic logic [15:0] wmask(input int k, input logic [15:0] v);
        return (k == 2) ? v : {8'h0, v[7:0]};
    endfunction

    function automatic logic [15:0] exp_rd(input int k, input logic [2:0] a);
        if (k == 1 && en && wsel == a) return wmask(k, d16);
        if (int'(a) < dep(k)) return m_mem[k][a];
        return 16'h0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (clr) begin
                for (int i = 0; i < 8; i++) m_mem[k][i] = 16'h0;
                m_wr[k] = 8'h0; m_dump[k] = 1'b0; m_idx[k] = 0; m_done[k] = 1'b0;
            end else begin
                m_done[k] = 1'b0;
                if (m_dump[k] && dump_ready) begin
                    if (m_idx[k] == dep(k) - 1) begin
                        m_dump[k] = 1'b0; m_idx[k] = 0; m_done[k] = 1'b1;
                    end else begin
                        m_idx[k] = m_idx[k] + 1;
                    end
                end else if (!m_dump[k] && dump_start) begin
                    m_dump[k] = 1'b1; m_idx[k] = 0;
                end
                if (en && int'(wsel) < dep(k)) begin
                    m_mem[k][wsel] = wmask(k, d16);
                    m_wr[k][wsel]  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("q0[%0d]", k), a_q0[k], exp_rd(k, rsel0));
                chk($sformatf("q1[%0d]", k), a_q1[k], exp_rd(k, rsel1));
                chk($sformatf("written[%0d]", k), a_wr[k], {8'h0, m_wr[k]});
                chk($sformatf("valid[%0d]", k), {15'h0, a_dv[k]}, {15'h0, m_dump[k]});
                chk($sformatf("busy[%0d]", k), {15'h0, a_db[k]}, {15'h0, m_dump[k]});
                chk($sformatf("done[%0d]", k), {15'h0, a_dn[k]}, {15'h0, m_done[k]});
                if (m_dump[k]) begin
                    chk($sformatf("daddr[%0d]", k), a_da[k], 16'(m_idx[k]));
                    chk($sformatf("ddata[%0d]", k), a_dd[k], exp_rd(k, 3'(m_idx[k])));
                end
            end
        end
    end

    logic [7:0] cap_d [$];
    logic [2:0] cap_a [$];
    int         cap_c;
    always @(negedge clk) begin
        if (dv_a && dump_ready) begin
            cap_d.push_back(dd_a);
            cap_a.push_back(da_a);
        end
        if (dv_c && dump_ready) cap_c++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_d.delete();
        cap_a.delete();
        cap_c = 0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        for (n = 0; n < 40 && !dn_a; n++) tick();
        chk({nm, "_done_seen"}, {15'h0, dn_a}, 16'h1);
    endtask

    task automatic start_dump();
        dump_start = 1'b1;
        dump_ready = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    logic [13:0] pat;

    initial begin
        tick();
        chk_on = 1'b1;
        clr = 1'b0;
        #1;
        chk("rst_written", {8'h0, wr_a}, 16'h0);
        chk("rst_q0", {8'h0, q0_a}, 16'h0);
        chk("rst_valid", {15'h0, dv_a}, 16'h0);

        // Fill entries; entries 5..7 are out of range for the 5-deep instance.
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wsel = 3'(i);
            d16  = 16'h1200 | 16'(8'hA0 + i);
            tick();
        end
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rsel0 = 3'(i);
            rsel1 = 3'(7 - i);
            #1;
            chk($sformatf("t1_q0_%0d", i), {8'h0, q0_a}, 16'(8'hA0 + i));
            chk($sformatf("t1_q1_%0d", i), {8'h0, q1_a}, 16'(8'hA7 - i));
            chk($sformatf("t6_q0_%0d", i), q0_c, (i < 5) ? (16'h12A0 + 16'(i)) : 16'h0);
            tick();
        end
        chk("t1_written", {8'h0, wr_a}, 16'h00FF);
        chk("t6_written", {11'h0, wr_c}, 16'h001F);

        en = 1'b1; wsel = 3'd3; d16 = 16'h005A; rsel0 = 3'd3;
        #1;
        chk("t2_old", {8'h0, q0_a}, 16'h00A3);
        chk("t2_bypass", {8'h0, q0_b}, 16'h005A);
        tick();
        en = 1'b0;
        #1;
        chk("t2_after", {8'h0, q0_a}, 16'h005A);
        en = 1'b1; d16 = 16'h00A3;
        tick();
        en = 1'b0;

        clear_caps();
        start_dump();
        wait_done("t3");
        chk("t3_beats", 16'(cap_d.size()), 16'd8);
        for (int i = 0; i < 8 && i < cap_d.size(); i++) begin
            chk($sformatf("t3_addr_%0d", i), {13'h0, cap_a[i]}, 16'(i));
            chk($sformatf("t3_data_%0d", i), {8'h0, cap_d[i]}, 16'(8'hA0 + i));
        end
        chk("t6_beats", 16'(cap_c), 16'd5);
        tick();
        chk("t3_busy_after", {15'h0, db_a}, 16'h0);

        clear_caps();
        pat = 14'b11100011100011;
        start_dump();
        for (int c = 0; c < 14; c++) begin
            dump_ready = pat[c];
            en   = (c == 2 || c == 3);
            wsel = (c == 2) ? 3'd6 : 3'd1;
            d16  = (c == 2) ? 16'h00EE : 16'h0011;
            #1;
            if (c == 3) chk("t4_hold2", {13'h0, da_a}, 16'd2);
            if (c == 9) chk("t4_hold5", {13'h0, da_a}, 16'd5);
            tick();
        end
        en = 1'b0;
        dump_ready = 1'b1;
        wait_done("t4");
        chk("t4_beats", 16'(cap_d.size()), 16'd8);
        if (cap_d.size() == 8) begin
            chk("t4_e6", {8'h0, cap_d[6]}, 16'h00EE);
            chk("t4_e1", {8'h0, cap_d[1]}, 16'h00A1);
            chk("t4_a7", {13'h0, cap_a[7]}, 16'd7);
        end

        start_dump();
        for (int c = 0; c < 4; c++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_valid", {15'h0, dv_a}, 16'h0);
        chk("t5_busy", {15'h0, db_a}, 16'h0);
        chk("t5_written", {8'h0, wr_a}, 16'h0);
        for (int c = 0; c < 3; c++) begin
            chk("t5_no_done", {15'h0, dn_a}, 16'h0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            rsel0 = 3'(i);
            #1;
            chk($sformatf("t5_zero_%0d", i), {8'h0, q0_a}, 16'h0);
        end
        clear_caps();
        start_dump();
        wait_done("t5");
        chk("t5_beats", 16'(cap_d.size()), 16'd8);
        foreach (cap_d[i]) chk($sformatf("t5_data_%0d", i), {8'h0, cap_d[i]}, 16'h0);

        for (int n = 0; n < 2000; n++) begin
            en         = 1'($urandom_range(0, 1));
            wsel       = 3'($urandom);
            d16        = 16'($urandom);
            rsel0      = 3'($urandom);
            rsel1      = 3'($urandom);
            dump_ready = ($urandom_range(0, 3) != 0);
            dump_start = ($urandom_range(0, 7) == 0);
            clr        = ($urandom_range(0, 96) == 0);
            tick();
        end
        clr = 1'b0; en = 1'b0; dump_start = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
